dmem_arbiter: RTL and testbench

Shares the single data-memory port between the scalar pipeline's MEM stage (driven by the EX/MEM pipeline register outputs) and the CGRA/vector unit's burst engine. Sequences one memory beat at a time against a variable-latency request/grant/rvalid memory. Produces the pipeline `Stall` that freezes the EX/MEM register and the earlier pipeline registers while the scalar access is pending.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_burst_ctr.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: arbiter FSM states and beat address stride.
// Optional perf counters are enabled with DMEM_ARB_PERF_EN (see dmem_arbiter).
package dmem_arb_pkg;

    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        CPU_REQ,
        CPU_RD,
        CG_REQ,
        CG_RD,
        CG_DONE
    } arb_state_e;

endpackage

// File: rtl/dmem_burst_ctr.sv
// CGRA burst beat counter: latches base and clamped length, produces the
// current beat address (wrapping modulo 2^32) and the last-beat flag.
module dmem_burst_ctr #(
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [31:0]      base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [31:0]      addr_o,
    output logic             last_o
);
    import dmem_arb_pkg::*;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    logic [31:0]      base_q, base_d;
    logic [LEN_W-1:0] last_q, last_d;
    logic [LEN_W-1:0] beat_q, beat_d;

    // last_q holds the index of the final beat, so 0 and 1 both mean one beat
    always_comb begin
        base_d = base_q;
        last_d = last_q;
        beat_d = beat_q;
        if (load_i) begin
            base_d = base_i;
            beat_d = '0;
            if (len_i == '0) begin
                last_d = '0;
            end else if (len_i > MAX_L) begin
                last_d = MAX_L - ONE;
            end else begin
                last_d = len_i - ONE;
            end
        end else if (adv_i) begin
            beat_d = beat_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q <= '0;
            last_q <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            last_q <= last_d;
            beat_q <= beat_d;
        end
    end

    assign addr_o = base_q + (32'(beat_q) * ADDR_STRIDE);
    assign last_o = (beat_q == last_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the scalar MEM stage and the CGRA burst
// engine. Define DMEM_ARB_PERF_EN to add stall-cycle and CGRA-beat counters.
module dmem_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_rd_i,
    input  logic             cpu_wr_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic [31:0]      cpu_rdata_o,
    output logic             stall_o,
    input  logic             cgra_req_i,
    input  logic             cgra_we_i,
    input  logic [31:0]      cgra_addr_i,
    input  logic [LEN_W-1:0] cgra_len_i,
    input  logic [31:0]      cgra_wdata_i,
    output logic             cgra_wready_o,
    output logic [31:0]      cgra_rdata_o,
    output logic             cgra_rvalid_o,
    output logic             cgra_done_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]      perf_stall_cyc_o,
    output logic [31:0]      perf_cgra_beats_o
`endif
);
    import dmem_arb_pkg::*;

    arb_state_e state_q, state_d;
    logic       last_cgra_q, last_cgra_d;
    logic       cg_we_q, cg_we_d;
    logic       cpu_pend;
    logic       cpu_done;
    logic       cg_beat;
    logic       ctr_load;
    logic       ctr_adv;
    logic       ctr_last;
    logic [31:0] ctr_addr;

    assign cpu_pend = cpu_rd_i | cpu_wr_i;

    dmem_burst_ctr #(
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (ctr_load),
        .adv_i  (ctr_adv),
        .base_i (cgra_addr_i),
        .len_i  (cgra_len_i),
        .addr_o (ctr_addr),
        .last_o (ctr_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_cgra_q <= 1'b0;
            cg_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_cgra_q <= last_cgra_d;
            cg_we_q     <= cg_we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cg_we_d  = cg_we_q;
        ctr_load = 1'b0;
        ctr_adv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // on a tie the CGRA wins unless it was the last one served
                if (cgra_req_i && (!cpu_pend || !last_cgra_q)) begin
                    state_d  = CG_REQ;
                    ctr_load = 1'b1;
                    cg_we_d  = cgra_we_i;
                end else if (cpu_pend) begin
                    state_d = CPU_REQ;
                end
            end
            CPU_REQ: begin
                if (mem_gnt_i) begin
                    state_d = cpu_wr_i ? IDLE : CPU_RD;
                end
            end
            CPU_RD: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            CG_REQ: begin
                if (mem_gnt_i) begin
                    if (!cg_we_q) begin
                        state_d = CG_RD;
                    end else if (ctr_last) begin
                        state_d = CG_DONE;
                    end else begin
                        ctr_adv = 1'b1;
                    end
                end
            end
            CG_RD: begin
                if (mem_rvalid_i) begin
                    if (ctr_last) begin
                        state_d = CG_DONE;
                    end else begin
                        ctr_adv = 1'b1;
                        state_d = CG_REQ;
                    end
                end
            end
            CG_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        cpu_rdata_o   = '0;
        cpu_done      = 1'b0;
        cgra_wready_o = 1'b0;
        cgra_rdata_o  = '0;
        cgra_rvalid_o = 1'b0;
        cgra_done_o   = 1'b0;
        cg_beat       = 1'b0;
        unique case (state_q)
            CPU_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = cpu_wr_i;
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wr_i ? cpu_wdata_i : '0;
                cpu_done    = mem_gnt_i & cpu_wr_i;
            end
            CPU_RD: begin
                cpu_done    = mem_rvalid_i;
                cpu_rdata_o = mem_rvalid_i ? mem_rdata_i : '0;
            end
            CG_REQ: begin
                mem_req_o     = 1'b1;
                mem_we_o      = cg_we_q;
                mem_addr_o    = ctr_addr;
                mem_wdata_o   = cg_we_q ? cgra_wdata_i : '0;
                cgra_wready_o = cg_we_q & mem_gnt_i;
                cg_beat       = cg_we_q & mem_gnt_i;
            end
            CG_RD: begin
                cgra_rvalid_o = mem_rvalid_i;
                cgra_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                cg_beat       = mem_rvalid_i;
            end
            CG_DONE: cgra_done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        last_cgra_d = last_cgra_q;
        if (state_q == CG_DONE) begin
            last_cgra_d = 1'b1;
        end else if (cpu_done) begin
            last_cgra_d = 1'b0;
        end
    end

    assign stall_o = cpu_pend & ~cpu_done;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] cg_beats_q, cg_beats_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        cg_beats_d  = cg_beats_q;
        if (stall_o && (stall_cyc_q != '1)) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
        if (cg_beat && (cg_beats_q != '1)) begin
            cg_beats_d = cg_beats_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cyc_q <= '0;
            cg_beats_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            cg_beats_q  <= cg_beats_d;
        end
    end

    assign perf_stall_cyc_o  = stall_cyc_q;
    assign perf_cgra_beats_o = cg_beats_q;
`else
    logic unused_beat;
    assign unused_beat = cg_beat;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small
// request/grant/rvalid memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 0, cpu_wr = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        cgra_req = 0, cgra_we = 0;
    logic [31:0] cgra_addr = 0, cgra_wdata = 0;
    logic [3:0]  cgra_len = 0;
    logic        cgra_wready, cgra_rvalid, cgra_done;
    logic [31:0] cgra_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall, perf_beats;
`endif

    localparam logic [31:0] K = 32'h5A5A_0000;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_rd_i      (cpu_rd),
        .cpu_wr_i      (cpu_wr),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata),
        .stall_o       (stall),
        .cgra_req_i    (cgra_req),
        .cgra_we_i     (cgra_we),
        .cgra_addr_i   (cgra_addr),
        .cgra_len_i    (cgra_len),
        .cgra_wdata_i  (cgra_wdata),
        .cgra_wready_o (cgra_wready),
        .cgra_rdata_o  (cgra_rdata),
        .cgra_rvalid_o (cgra_rvalid),
        .cgra_done_o   (cgra_done),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cyc_o  (perf_stall),
        .perf_cgra_beats_o (perf_beats)
`endif
    );

    // memory model: grant while not blocked, read data rv_lat cycles later
    bit          gnt_block = 0;
    bit          rv_hold = 0;
    int          rv_lat = 1;
    logic        rd_pend;
    int          rv_wait;
    logic [31:0] rd_addr;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wd[$];

    assign mem_gnt    = mem_req & ~gnt_block;
    assign mem_rvalid = rd_pend & (rv_wait == 0) & ~rv_hold;
    assign mem_rdata  = mem_rvalid ? (rd_addr ^ K) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rv_wait <= 0;
            rd_addr <= '0;
        end else if (mem_req && mem_gnt) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wd.push_back(mem_wdata);
            if (!mem_we) begin
                rd_pend <= 1'b1;
                rd_addr <= mem_addr;
                rv_wait <= rv_lat - 1;
            end
        end else if (rd_pend) begin
            if (mem_rvalid) rd_pend <= 1'b0;
            else if (rv_wait > 0) rv_wait <= rv_wait - 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          done_cyc, cpu_cyc, stall_n, wrdy_n, rv_n;
    logic [31:0] cpu_rdv;
    logic [31:0] cg_rd[$];

    // drives one CPU access (starting at cycle c_dly) and/or one burst
    task automatic run(input bit c_en, input bit c_wr,
                       input logic [31:0] c_addr, input logic [31:0] c_wd,
                       input int c_dly, input bit g_en, input bit g_we,
                       input logic [31:0] g_base, input logic [3:0] g_len);
        bit c_busy, c_fin, g_fin, drop_c, drop_g, adv_w;
        int cyc;
        c_busy = 0; c_fin = !c_en; g_fin = !g_en; cyc = 0;
        done_cyc = -1; cpu_cyc = -1; stall_n = 0; wrdy_n = 0; rv_n = 0;
        cpu_rdv = '0;
        log_addr.delete(); log_we.delete(); log_wd.delete(); cg_rd.delete();
        if (g_en) begin
            cgra_req = 1; cgra_we = g_we; cgra_addr = g_base;
            cgra_len = g_len; cgra_wdata = 32'hD000_0000;
        end
        while (!(c_fin && g_fin) && cyc < 200) begin
            if (c_en && !c_busy && !c_fin && cyc == c_dly) begin
                cpu_rd = !c_wr; cpu_wr = c_wr;
                cpu_addr = c_addr; cpu_wdata = c_wd;
                c_busy = 1;
            end
            @(negedge clk);
            drop_c = 0; drop_g = 0; adv_w = 0;
            if (stall) stall_n++;
            if (cgra_wready) begin wrdy_n++; adv_w = 1; end
            if (cgra_rvalid) begin rv_n++; cg_rd.push_back(cgra_rdata); end
            if (cgra_done) begin done_cyc = cyc; g_fin = 1; drop_g = 1; end
            if (c_busy && !stall) begin
                cpu_cyc = cyc; cpu_rdv = cpu_rdata; c_fin = 1; drop_c = 1;
            end
            @(posedge clk); #1;
            if (adv_w) cgra_wdata = cgra_wdata + 32'd1;
            if (drop_g) cgra_req = 0;
            if (drop_c) begin cpu_rd = 0; cpu_wr = 0; c_busy = 0; end
            cyc++;
        end
        chk("timeout", 32'(cyc >= 200), 0);
    endtask

    int ndone;

    initial begin
        repeat (2) @(posedge clk); #1;
        chk("rst_req", mem_req, 0);
        chk("rst_stall_idle", stall, 0);
        cpu_rd = 1; #1;
        chk("rst_stall_pend", stall, 1);
        chk("rst_done", cgra_done, 0);
        cpu_rd = 0;
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        // CPU load, rvalid two cycles after grant
        rv_lat = 2;
        run(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("ld_stall_n", stall_n, 3);
        chk("ld_rel_cyc", cpu_cyc, 3);
        chk("ld_rdata", cpu_rdv, 32'h5A5A_0100);
        chk("ld_addr", log_addr[0], 32'h100);
        rv_lat = 1;

        // CPU store, zero-wait grant
        run(1, 1, 32'h104, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        chk("st_stall_n", stall_n, 1);
        chk("st_rel_cyc", cpu_cyc, 1);
        chk("st_we", log_we[0], 1);
        chk("st_wd", log_wd[0], 32'hCAFE_F00D);

        // CGRA write burst len 4
        run(0, 0, 0, 0, 0, 1, 1, 32'h200, 4'd4);
        chk("wb_done_cyc", done_cyc, 5);
        chk("wb_wready_n", wrdy_n, 4);
        chk("wb_nbeats", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb_addr%0d", i), log_addr[i], 32'h200 + 32'(4 * i));
            chk($sformatf("wb_wd%0d", i), log_wd[i], 32'hD000_0000 + 32'(i));
        end

        // tie from reset: CGRA first
        rst = 1; #2; rst = 0;
        @(posedge clk); #1;
        run(1, 0, 32'h300, 0, 0, 1, 0, 32'h400, 4'd1);
        chk("tie1_first", log_addr[0], 32'h400);
        chk("tie1_second", log_addr[1], 32'h300);
        chk("tie1_done_cyc", done_cyc, 3);
        chk("tie1_cpu_cyc", cpu_cyc, 6);
        chk("tie1_cg_rdata", cg_rd[0], 32'h5A5A_0400);
        chk("tie1_cpu_rdata", cpu_rdv, 32'h5A5A_0300);

        // after a CGRA-only burst, the next tie goes to the CPU
        run(0, 0, 0, 0, 0, 1, 1, 32'h500, 4'd1);
        chk("solo_done_cyc", done_cyc, 2);
        run(1, 1, 32'h510, 32'h1234_5678, 0, 1, 0, 32'h520, 4'd1);
        chk("tie2_first", log_addr[0], 32'h510);
        chk("tie2_cpu_cyc", cpu_cyc, 1);
        chk("tie2_done_cyc", done_cyc, 5);

        // store arriving mid read burst waits for the whole burst
        run(1, 1, 32'h700, 32'hBEEF_0001, 3, 1, 0, 32'h600, 4'd8);
        chk("mid_done_cyc", done_cyc, 17);
        chk("mid_rv_n", rv_n, 8);
        chk("mid_cpu_cyc", cpu_cyc, 19);
        chk("mid_stall_n", stall_n, 16);
        chk("mid_nbeats", log_addr.size(), 9);
        chk("mid_st_addr", log_addr[8], 32'h700);
        chk("mid_rd7", cg_rd[7], 32'h5A5A_061C);

        // address wrap past the top of memory
        run(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 4'd4);
        chk("wrap_a1", log_addr[1], 32'hFFFF_FFFC);
        chk("wrap_a2", log_addr[2], 32'h0);
        chk("wrap_a3", log_addr[3], 32'h4);

        // length 0 means one beat, length 15 clamps to MAX_BURST
        run(0, 0, 0, 0, 0, 1, 1, 32'h800, 4'd0);
        chk("len0_wready_n", wrdy_n, 1);
        chk("len0_done_cyc", done_cyc, 2);
        run(0, 0, 0, 0, 0, 1, 0, 32'h900, 4'd15);
        chk("len15_rv_n", rv_n, 8);
        chk("len15_done_cyc", done_cyc, 17);
        chk("len15_last", log_addr[7], 32'h91C);

        // reset while a CGRA request waits for grant: mem_req drops at once
        gnt_block = 1;
        cgra_req = 1; cgra_we = 1; cgra_addr = 32'hB00; cgra_len = 4'd2;
        @(posedge clk); #1;
        chk("blk_req", mem_req, 1);
        chk("blk_addr", mem_addr, 32'hB00);
        #2 rst = 1; #1;
        chk("blk_rst_req", mem_req, 0);
        @(negedge clk) rst = 0;
        gnt_block = 0;

        // reset while CG_RD waits on rvalid: no done pulse
        rv_hold = 1;
        cgra_we = 0; cgra_addr = 32'hA00;
        repeat (3) @(posedge clk); #1;
        chk("rdw_rvalid", cgra_rvalid, 0);
        #2 rst = 1; #1;
        chk("rdw_rst_req", mem_req, 0);
        cgra_req = 0; rv_hold = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cgra_done) ndone++;
            if (i == 1) rst = 0;
        end
        chk("rdw_no_done", ndone, 0);
        @(posedge clk); #1;
        run(1, 1, 32'hC00, 32'h0, 0, 0, 0, 0, 0);
        chk("post_rst_cpu_cyc", cpu_cyc, 1);
        chk("post_rst_addr", log_addr[0], 32'hC00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
